// File: rtl/prefix_adder_pipe.sv
// prefix_adder_pipe: pipelined Kogge-Stone adder/subtractor with global-stall valid/ready flow control.
// Optional tag sideband travelling with each operation: define PREFIX_ADDER_TAG_EN.
module prefix_adder_pipe #(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned LEVELS = $clog2(WIDTH),
  parameter int unsigned TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef PREFIX_ADDER_TAG_EN
  input  logic [TAG_W-1:0] in_tag,
  output logic [TAG_W-1:0] out_tag,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned MSB = WIDTH - 1;
  // Propagate terms are only needed between levels, never after the last one.
  localparam int unsigned PW  = (LEVELS > 1) ? LEVELS - 1 : 1;

  if (WIDTH < 2 || WIDTH > 128 || LEVELS != $clog2(WIDTH) || TAG_W < 1) begin : g_param_check
    $error("prefix_adder_pipe: illegal parameterisation");
  end

  logic                         adv;
  logic                         s0_valid;
  logic [WIDTH-1:0]             s0_a;
  logic [WIDTH-1:0]             s0_b;
  logic                         s0_cin;
  logic [LEVELS-1:0]            lv_valid;
  logic [LEVELS-1:0]            lv_cin;
  logic [LEVELS-1:0]            lv_amsb;
  logic [LEVELS-1:0][WIDTH-1:0] lv_g;
  logic [LEVELS-1:0][WIDTH-1:0] lv_po;
  logic [PW-1:0][WIDTH-1:0]     lv_p;
  logic [LEVELS-1:0]            prev_valid;
  logic [LEVELS-1:0]            prev_cin;
  logic [LEVELS-1:0]            prev_amsb;
  logic [LEVELS-1:0][WIDTH-1:0] prev_po;
  logic [LEVELS-1:0][WIDTH-1:0] in_g;
  logic [LEVELS-1:0][WIDTH-1:0] in_p;
  logic [LEVELS-1:0][WIDTH-1:0] nxt_g;
  logic [PW-1:0][WIDTH-1:0]     nxt_p;
  logic [WIDTH-1:0]             sum_c;
  logic                         cout_c;
  logic                         ovf_c;

  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  // Level inputs: level 0 reads g/p formed from S0, with cin folded into bit 0's generate.
  always_comb begin
    prev_valid = '0;
    prev_cin   = '0;
    prev_amsb  = '0;
    prev_po    = '0;
    in_g       = '0;
    in_p       = '0;
    prev_valid[0] = s0_valid;
    prev_cin[0]   = s0_cin;
    prev_amsb[0]  = s0_a[MSB];
    prev_po[0]    = s0_a ^ s0_b;
    in_g[0]       = s0_a & s0_b;
    in_g[0][0]    = (s0_a[0] & s0_b[0]) | ((s0_a[0] ^ s0_b[0]) & s0_cin);
    in_p[0]       = s0_a ^ s0_b;
    for (int unsigned k = 1; k < LEVELS; k++) begin
      prev_valid[k] = lv_valid[k-1];
      prev_cin[k]   = lv_cin[k-1];
      prev_amsb[k]  = lv_amsb[k-1];
      prev_po[k]    = lv_po[k-1];
      in_g[k]       = lv_g[k-1];
      in_p[k]       = lv_p[k-1];
    end
  end

  // One Kogge-Stone level per stage at distance 2^k; low bits with no partner pass through.
  always_comb begin
    nxt_g = '0;
    nxt_p = '0;
    for (int unsigned k = 0; k < LEVELS; k++) begin
      nxt_g[k] = in_g[k] | (in_p[k] & (in_g[k] << (1 << k)));
    end
    for (int unsigned k = 0; k + 1 < LEVELS; k++) begin
      nxt_p[k] = in_p[k] & ((in_p[k] << (1 << k)) | ((WIDTH'(1) << (1 << k)) - WIDTH'(1)));
    end
  end

  // Result formation: carry into bit i is the fully resolved group generate of bit i-1.
  always_comb begin
    sum_c  = lv_po[LEVELS-1] ^ {lv_g[LEVELS-1][WIDTH-2:0], lv_cin[LEVELS-1]};
    cout_c = lv_g[LEVELS-1][MSB];
    ovf_c  = ~lv_po[LEVELS-1][MSB] & (sum_c[MSB] ^ lv_amsb[LEVELS-1]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_valid  <= 1'b0;
      s0_a      <= '0;
      s0_b      <= '0;
      s0_cin    <= 1'b0;
      lv_valid  <= '0;
      lv_cin    <= '0;
      lv_amsb   <= '0;
      lv_g      <= '0;
      lv_p      <= '0;
      lv_po     <= '0;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
    end else begin
      if (adv) begin
        s0_valid  <= in_valid;
        s0_a      <= a;
        s0_b      <= op_sub ? ~b : b;
        s0_cin    <= cin;
        lv_valid  <= prev_valid;
        lv_cin    <= prev_cin;
        lv_amsb   <= prev_amsb;
        lv_g      <= nxt_g;
        lv_p      <= nxt_p;
        lv_po     <= prev_po;
        out_valid <= lv_valid[LEVELS-1];
        sum       <= sum_c;
        cout      <= cout_c;
        ovf       <= ovf_c;
        zero      <= ~|sum_c;
      end
      // Flush kills every in-flight word, stalled or not; data may stay stale.
      if (flush) begin
        s0_valid  <= 1'b0;
        lv_valid  <= '0;
        out_valid <= 1'b0;
      end
    end
  end

`ifdef PREFIX_ADDER_TAG_EN
  logic [TAG_W-1:0]             s0_tag;
  logic [LEVELS-1:0][TAG_W-1:0] lv_tag;
  logic [LEVELS-1:0][TAG_W-1:0] prev_tag;

  always_comb begin
    prev_tag    = '0;
    prev_tag[0] = s0_tag;
    for (int unsigned k = 1; k < LEVELS; k++) begin
      prev_tag[k] = lv_tag[k-1];
    end
  end

  // Tags carry no valid of their own; they ride the shared advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_tag  <= '0;
      lv_tag  <= '0;
      out_tag <= '0;
    end else if (adv) begin
      s0_tag  <= in_tag;
      lv_tag  <= prev_tag;
      out_tag <= lv_tag[LEVELS-1];
    end
  end
`endif

endmodule

// File: tb/tb_prefix_adder_pipe.sv
// Self-checking bench for prefix_adder_pipe: WIDTH=64 directed/flow-control scenarios and
// a WIDTH=13 randomized run scored against an arithmetic reference model.
module tb_prefix_adder_pipe;

  localparam int unsigned TW = 4;

  logic        clk;
  logic        rst;
  logic        flush;

  logic        iv64, ir64, sub64, cin64, ov64, ordy64, cout64, ovf64, zero64;
  logic [63:0] a64, b64, sum64;
  logic        iv13, ir13, sub13, cin13, ov13, ordy13, cout13, ovf13, zero13;
  logic [12:0] a13, b13, sum13;
  logic [TW-1:0] itag13;
`ifdef PREFIX_ADDER_TAG_EN
  logic [TW-1:0] itag64, otag64, otag13;
`endif

  int checks;
  int failures;

  typedef struct packed {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } res64_t;

  typedef struct packed {
    logic [12:0]   sum;
    logic          cout;
    logic          ovf;
    logic          zero;
    logic [TW-1:0] tag;
  } res13_t;

  res64_t q64[$];
  res13_t q13[$];
  logic   held64_v;
  res64_t held64;
  logic   held13_v;
  logic [15:0] held13;
  int     n_out64;
  int     n_out13;
  int     seq13;

  prefix_adder_pipe #(.WIDTH(64), .TAG_W(TW)) u64 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(iv64), .in_ready(ir64), .op_sub(sub64), .cin(cin64), .a(a64), .b(b64),
`ifdef PREFIX_ADDER_TAG_EN
    .in_tag(itag64), .out_tag(otag64),
`endif
    .out_valid(ov64), .out_ready(ordy64), .sum(sum64), .cout(cout64), .ovf(ovf64), .zero(zero64)
  );

  prefix_adder_pipe #(.WIDTH(13), .TAG_W(TW)) u13 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(iv13), .in_ready(ir13), .op_sub(sub13), .cin(cin13), .a(a13), .b(b13),
`ifdef PREFIX_ADDER_TAG_EN
    .in_tag(itag13), .out_tag(otag13),
`endif
    .out_valid(ov13), .out_ready(ordy13), .sum(sum13), .cout(cout13), .ovf(ovf13), .zero(zero13)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain unsigned and signed arithmetic on widened operands.
  function automatic res64_t model64(input logic s, input logic c, input logic [63:0] x, input logic [63:0] y);
    res64_t r;
    logic [63:0] ye;
    logic [64:0] u;
    logic signed [65:0] sg;
    ye = s ? ~y : y;
    u  = {1'b0, x} + {1'b0, ye} + {64'd0, c};
    sg = $signed({{2{x[63]}}, x}) + $signed({{2{ye[63]}}, ye}) + $signed({65'd0, c});
    r.sum  = u[63:0];
    r.cout = u[64];
    r.ovf  = (sg != $signed({{2{u[63]}}, u[63:0]}));
    r.zero = (u[63:0] == 64'd0);
    return r;
  endfunction

  function automatic res13_t model13(input logic s, input logic c, input logic [12:0] x, input logic [12:0] y,
                                     input logic [TW-1:0] t);
    res13_t r;
    logic [12:0] ye;
    logic [13:0] u;
    logic signed [14:0] sg;
    ye = s ? ~y : y;
    u  = {1'b0, x} + {1'b0, ye} + {13'd0, c};
    sg = $signed({{2{x[12]}}, x}) + $signed({{2{ye[12]}}, ye}) + $signed({14'd0, c});
    r.sum  = u[12:0];
    r.cout = u[13];
    r.ovf  = (sg != $signed({{2{u[12]}}, u[12:0]}));
    r.zero = (u[12:0] == 13'd0);
    r.tag  = t;
    return r;
  endfunction

  task automatic cycle64(input logic iv, input logic s, input logic c, input logic [63:0] x,
                         input logic [63:0] y, input logic ordy, output logic acc);
    res64_t got;
    res64_t exp;
    @(negedge clk);
    iv64 = iv; sub64 = s; cin64 = c; a64 = x; b64 = y; ordy64 = ordy;
    #1;
    got = {sum64, cout64, ovf64, zero64};
    checks++;
    if (ir64 !== (~ov64 | ordy)) begin
      failures++;
      $display("FAIL in_ready64: got %b want %b", ir64, ~ov64 | ordy);
    end
    if (held64_v) begin
      checks++;
      if (ov64 !== 1'b1 || got !== held64) begin
        failures++;
        $display("FAIL hold64: got valid=%b res=%h want valid=1 res=%h", ov64, got, held64);
      end
    end
    if (ov64 === 1'b1 && ordy) begin
      checks++;
      if (q64.size() == 0) begin
        failures++;
        $display("FAIL spurious64: got result %h want no valid output", got);
      end else begin
        exp = q64.pop_front();
        n_out64++;
        if (got !== exp) begin
          failures++;
          $display("FAIL result64: got %h want %h", got, exp);
        end
      end
    end
    held64_v = (ov64 === 1'b1) && !ordy;
    held64   = got;
    acc = iv && (ir64 === 1'b1);
    if (acc) q64.push_back(model64(s, c, x, y));
  endtask

  task automatic cycle13(input logic iv, input logic s, input logic c, input logic [12:0] x,
                         input logic [12:0] y, input logic ordy, output logic acc);
    logic [15:0] got;
    res13_t exp;
    @(negedge clk);
    iv13 = iv; sub13 = s; cin13 = c; a13 = x; b13 = y; ordy13 = ordy;
    itag13 = seq13[TW-1:0];
    #1;
    got = {sum13, cout13, ovf13, zero13};
    checks++;
    if (ir13 !== (~ov13 | ordy)) begin
      failures++;
      $display("FAIL in_ready13: got %b want %b", ir13, ~ov13 | ordy);
    end
    if (held13_v) begin
      checks++;
      if (ov13 !== 1'b1 || got !== held13) begin
        failures++;
        $display("FAIL hold13: got valid=%b res=%h want valid=1 res=%h", ov13, got, held13);
      end
    end
    if (ov13 === 1'b1 && ordy) begin
      checks++;
      if (q13.size() == 0) begin
        failures++;
        $display("FAIL spurious13: got result %h want no valid output", got);
      end else begin
        exp = q13.pop_front();
        n_out13++;
        if (got !== {exp.sum, exp.cout, exp.ovf, exp.zero}) begin
          failures++;
          $display("FAIL result13: got sum=%h c=%b v=%b z=%b want sum=%h c=%b v=%b z=%b",
                   sum13, cout13, ovf13, zero13, exp.sum, exp.cout, exp.ovf, exp.zero);
        end
`ifdef PREFIX_ADDER_TAG_EN
        checks++;
        if (otag13 !== exp.tag) begin
          failures++;
          $display("FAIL tag13: got %h want %h", otag13, exp.tag);
        end
`endif
      end
    end
    held13_v = (ov13 === 1'b1) && !ordy;
    held13   = got;
    acc = iv && (ir13 === 1'b1);
    if (acc) begin
      q13.push_back(model13(s, c, x, y, seq13[TW-1:0]));
      seq13++;
    end
  endtask

  // Single op into an empty pipe with out_ready=1; checks latency and every output field.
  task automatic run_dir64(input string name, input logic s, input logic c, input logic [63:0] x,
                           input logic [63:0] y, input logic [63:0] esum, input logic ecout,
                           input logic eovf, input logic ezero);
    int lat;
    @(negedge clk);
    iv64 = 1'b1; sub64 = s; cin64 = c; a64 = x; b64 = y; ordy64 = 1'b1;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      #1;
      iv64 = 1'b0;
    end while (ov64 !== 1'b1 && lat < 20);
    checks++;
    if (lat != 8) begin failures++; $display("FAIL %s_latency: got %0d want 8", name, lat); end
    checks++;
    if (sum64 !== esum) begin failures++; $display("FAIL %s_sum: got %h want %h", name, sum64, esum); end
    checks++;
    if (cout64 !== ecout) begin failures++; $display("FAIL %s_cout: got %b want %b", name, cout64, ecout); end
    checks++;
    if (ovf64 !== eovf) begin failures++; $display("FAIL %s_ovf: got %b want %b", name, ovf64, eovf); end
    checks++;
    if (zero64 !== ezero) begin failures++; $display("FAIL %s_zero: got %b want %b", name, zero64, ezero); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if ({ov64, sum64, cout64, ovf64, zero64} !== 68'd0) begin
      failures++;
      $display("FAIL reset64: got valid=%b sum=%h c=%b v=%b z=%b want all 0", ov64, sum64, cout64, ovf64, zero64);
    end
    checks++;
    if ({ov13, sum13, cout13, ovf13, zero13} !== 17'd0) begin
      failures++;
      $display("FAIL reset13: got %h want 0", {ov13, sum13, cout13, ovf13, zero13});
    end
`ifdef PREFIX_ADDER_TAG_EN
    checks++;
    if (otag13 !== '0) begin failures++; $display("FAIL reset_tag: got %h want 0", otag13); end
`endif
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (ir64 !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b want 1", ir64); end
  endtask

  task automatic test_latency();
    run_dir64("latency", 1'b0, 1'b0, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'h0000_0001_0000_0000, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_wrap_ovf();
    run_dir64("wrap", 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1, 1'b0, 1'b1);
    run_dir64("sovf", 1'b0, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_subtract();
    run_dir64("sub_borrow", 1'b1, 1'b1, 64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0);
    run_dir64("sub_pos", 1'b1, 1'b1, 64'd7, 64'd5, 64'd2, 1'b1, 1'b0, 1'b0);
    run_dir64("sub_zero", 1'b1, 1'b1, 64'd0, 64'd0, 64'd0, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_latency13();
    int lat;
    @(negedge clk);
    iv13 = 1'b1; sub13 = 1'b0; cin13 = 1'b0; a13 = 13'h0FFF; b13 = 13'd1; ordy13 = 1'b1;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      #1;
      iv13 = 1'b0;
    end while (ov13 !== 1'b1 && lat < 20);
    checks++;
    if (lat != 6) begin failures++; $display("FAIL latency13: got %0d want 6", lat); end
    checks++;
    if ({sum13, cout13, ovf13, zero13} !== {13'h1000, 1'b0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL dir13: got sum=%h c=%b v=%b z=%b want sum=1000 c=0 v=1 z=0", sum13, cout13, ovf13, zero13);
    end
  endtask

  task automatic test_backpressure();
    int issued;
    int cyc;
    logic acc;
    q64.delete();
    held64_v = 1'b0;
    n_out64  = 0;
    issued   = 0;
    cyc      = 0;
    while ((issued < 20 || q64.size() > 0) && cyc < 400) begin
      cycle64(issued < 20, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), {$urandom, $urandom},
              {$urandom, $urandom}, (cyc % 4 == 0) || (cyc % 4 == 3), acc);
      if (acc) issued++;
      cyc++;
    end
    checks++;
    if (issued != 20 || n_out64 != 20 || q64.size() != 0) begin
      failures++;
      $display("FAIL backpressure_count: got issued=%0d out=%0d pending=%0d want 20/20/0", issued, n_out64, q64.size());
    end
    @(negedge clk);
    iv64 = 1'b0; ordy64 = 1'b1;
  endtask

  task automatic test_flush();
    logic acc;
    int n;
    int w;
    held64_v = 1'b0;
    for (int i = 0; i < 5; i++) cycle64(1'b1, 1'b0, 1'b0, 64'(i + 1), 64'(i * 3), 1'b1, acc);
    @(negedge clk);
    flush = 1'b1; iv64 = 1'b1; a64 = 64'd99; b64 = 64'd1;
    #1;
    checks++;
    if (ir64 !== 1'b1) begin failures++; $display("FAIL flush_in_ready: got %b want 1", ir64); end
    @(negedge clk);
    flush = 1'b0; iv64 = 1'b0;
    q64.delete();
    n = 0;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (ov64 !== 1'b0) n++;
      @(negedge clk);
    end
    checks++;
    if (n != 0) begin failures++; $display("FAIL flush_inflight: got %0d valid cycles want 0", n); end
    // Flush while the output is stalled.
    iv64 = 1'b1; a64 = 64'd3; b64 = 64'd4; sub64 = 1'b0; cin64 = 1'b0; ordy64 = 1'b0;
    @(negedge clk);
    iv64 = 1'b0;
    w = 0;
    while (ov64 !== 1'b1 && w < 20) begin @(negedge clk); w++; end
    checks++;
    if (ov64 !== 1'b1) begin failures++; $display("FAIL stall_fill: got valid=%b want 1", ov64); end
    flush = 1'b1;
    #1;
    checks++;
    if (ir64 !== 1'b0) begin failures++; $display("FAIL flush_stall_ready: got %b want 0", ir64); end
    @(posedge clk);
    #1;
    flush = 1'b0;
    checks++;
    if (ov64 !== 1'b0) begin failures++; $display("FAIL flush_stalled: got valid=%b want 0", ov64); end
    ordy64 = 1'b1;
    q64.delete();
    held64_v = 1'b0;
  endtask

  task automatic test_async_reset();
    int w;
    @(negedge clk);
    iv64 = 1'b1; a64 = 64'h1234; b64 = 64'h4321; sub64 = 1'b0; cin64 = 1'b0; ordy64 = 1'b0;
    @(negedge clk);
    iv64 = 1'b0;
    w = 0;
    while (ov64 !== 1'b1 && w < 20) begin @(negedge clk); w++; end
    checks++;
    if (ov64 !== 1'b1 || sum64 !== 64'h5555) begin
      failures++;
      $display("FAIL areset_prep: got valid=%b sum=%h want valid=1 sum=5555", ov64, sum64);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({ov64, sum64, cout64, ovf64, zero64} !== 68'd0) begin
      failures++;
      $display("FAIL areset_async: got valid=%b sum=%h want valid=0 sum=0 before clock edge", ov64, sum64);
    end
    @(negedge clk);
    rst = 1'b0; ordy64 = 1'b1;
    #1;
    checks++;
    if (ir64 !== 1'b1 || ov64 !== 1'b0) begin
      failures++;
      $display("FAIL areset_after: got ready=%b valid=%b want ready=1 valid=0", ir64, ov64);
    end
    q64.delete();
    held64_v = 1'b0;
  endtask

  task automatic test_random13();
    int issued;
    int cyc;
    logic acc;
    logic [12:0] x;
    logic [12:0] y;
    q13.delete();
    held13_v = 1'b0;
    n_out13  = 0;
    issued   = 0;
    cyc      = 0;
    while ((issued < 1000 || q13.size() > 0) && cyc < 6000) begin
      x = 13'($urandom);
      y = 13'($urandom);
      if ($urandom_range(0, 7) == 0) x = 13'h1FFF;
      if ($urandom_range(0, 7) == 0) y = 13'd0;
      cycle13((issued < 1000) && ($urandom_range(0, 99) < 85), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), x, y, (issued >= 1000) || ($urandom_range(0, 99) < 75), acc);
      if (acc) issued++;
      cyc++;
    end
    checks++;
    if (issued != 1000 || n_out13 != 1000 || q13.size() != 0) begin
      failures++;
      $display("FAIL random13_count: got issued=%0d out=%0d pending=%0d want 1000/1000/0", issued, n_out13, q13.size());
    end
    @(negedge clk);
    iv13 = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0; n_out64 = 0; n_out13 = 0; seq13 = 0;
    held64_v = 1'b0; held64 = '0; held13_v = 1'b0; held13 = '0;
    flush = 1'b0;
    iv64 = 1'b0; sub64 = 1'b0; cin64 = 1'b0; a64 = '0; b64 = '0; ordy64 = 1'b1;
    iv13 = 1'b0; sub13 = 1'b0; cin13 = 1'b0; a13 = '0; b13 = '0; ordy13 = 1'b1; itag13 = '0;
`ifdef PREFIX_ADDER_TAG_EN
    itag64 = '0;
`endif
    test_reset();
    test_latency();
    test_wrap_ovf();
    test_subtract();
    test_latency13();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random13();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got simulation still running want finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/prefix_adder_pipe.md
Name: prefix_adder_pipe

Overview:
- Parametrised, fully pipelined parallel-prefix (Kogge-Stone) adder/subtractor; successor to the fixed 64-bit pipelined adder.
- Adds: generic WIDTH, carry-in, subtract mode, carry/overflow/zero flags, valid/ready flow control with backpressure, synchronous flush.
- Sits in the execute datapath feeding the ALU result mux; one new operation accepted per cycle when not stalled.

Parameters:
- WIDTH, 64, operand/result width in bits; legal range 2..128, any value (not only powers of two).
- LEVELS, $clog2(WIDTH), number of prefix levels, one pipeline stage per level. Derived; must not be overridden.
- TAG_W, 4, width of the optional tag field. Used only when PREFIX_ADDER_TAG_EN is defined.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous kill of all in-flight operations.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept this cycle.
- op_sub  in  1  0 = add, 1 = subtract.
- cin  in  1  carry-in.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- in_tag  in  TAG_W  present only with PREFIX_ADDER_TAG_EN.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  result.
- cout  out  1  carry out of the MSB.
- ovf  out  1  signed overflow.
- zero  out  1  sum == 0.
- out_tag  out  TAG_W  present only with PREFIX_ADDER_TAG_EN.

Behaviour:
- Clock and reset: one clock domain. rst is asynchronous and active-high; it clears every pipeline register (valid bits, data, flags) to 0.
- Reset values: out_valid=0, sum=0, cout=0, ovf=0, zero=0, out_tag=0. in_ready is 1 once rst deasserts.
- Operand formation: b_eff = op_sub ? ~b : b. Result = a + b_eff + cin, in both modes.
  - Plain subtract requires cin=1.
  - Multiword subtract chains cout back into cin as a not-borrow.
- Pipeline, total latency LEVELS+2 cycles (8 for WIDTH=64):
  - S0 registers a, b_eff, cin, op and valid.
  - S0 combinational logic forms g = a & b_eff and p = a ^ b_eff. cin is injected as the generate into bit -1, so bit 0 carry = g0 | p0&cin.
  - S1..S(LEVELS): each stage does one Kogge-Stone level at distance 2^(k-1). Bits whose span runs past bit 0 pass through unchanged.
  - Output stage: sum = p_orig ^ {carry[WIDTH-2:0], cin}. p_orig is carried forward unchanged from S0.
  - cout = carry[WIDTH-1].
  - ovf = (a[MSB] == b_eff[MSB]) & (sum[MSB] != a[MSB]).
  - zero = ~|sum.
- Flow control, one global advance: adv = ~out_valid | out_ready.
  - in_ready = adv.
  - All stages load only when adv=1. When adv=0, every stage holds, valid bits included.
  - A transfer happens when in_valid & in_ready. Bubbles (valid=0) travel through the pipe like data.
  - Throughput is one result per cycle while out_ready stays 1.
- out_valid is set only by a valid word reaching the output stage. It stays 1, with sum and flags stable, until out_ready=1.
- flush: all valid bits clear on the next edge, whether stalled or not. Data registers may keep stale values.
  - If in_valid is high in the same cycle, the input is discarded.
  - in_ready follows adv as usual.
- Reset mid-operation: everything in flight is lost and out_valid=0 immediately (asynchronous clear).
- Boundary cases:
  - all-ones + 1 wraps to 0 with cout=1 and zero=1.
  - 0 - 0 with cin=1 gives sum=0, cout=1, zero=1.
  - Non-power-of-two WIDTH: the carry into the top bit is complete after LEVELS levels.

Optional Feature:
- Macro: PREFIX_ADDER_TAG_EN.
- When defined: in_tag/out_tag ports exist. The tag moves in lockstep with its operation, so out_tag is the in_tag of the operation now on sum. The tag follows the same stall and flush rules, and the tag registers reset to 0.
- When not defined: the ports and registers are absent and there is no tag logic.

Test Plan:
- Latency: WIDTH=64, out_ready=1. One op a=0x0000_0000_FFFF_FFFF, b=1, cin=0, add. Expect out_valid exactly 8 cycles later, sum=0x0000_0001_0000_0000, cout=0, ovf=0, zero=0.
- Wrap and signed overflow: a=0xFFFF_FFFF_FFFF_FFFF, b=1 gives sum=0, cout=1, zero=1, ovf=0. Then a=0x7FFF_FFFF_FFFF_FFFF, b=1 gives sum=0x8000_0000_0000_0000, ovf=1, cout=0.
- Subtract: op_sub=1, cin=1, a=5, b=7 gives sum=0xFFFF_FFFF_FFFF_FFFE, cout=0 (borrow). Then a=7, b=5 gives sum=2, cout=1.
- Backpressure: stream 20 back-to-back ops with out_ready toggling 1,0,0,1,... Expect in_ready == ~out_valid | out_ready every cycle, results in order with none lost or duplicated, and sum held stable while stalled.
- Flush and reset: 5 ops in flight, pulse flush for 1 cycle, expect no out_valid for those ops. Separately, assert rst asynchronously mid-stream and expect out_valid to drop to 0 without waiting for a clock edge.
- WIDTH=13 instance (LEVELS=4, latency 6), 1000 random ops against a reference model (a + b_eff + cin), checking sum, cout, ovf and zero. With PREFIX_ADDER_TAG_EN defined, out_tag must match the issued sequence number.
